seg_scan: RTL and testbench
===========================

SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter NDIGITS, default 8, number of multiplexed hex digits (1..16).
REQ-002 Parameter CLK_DIV, default 1000, clock cycles each digit is held (>=2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 data  input  4*NDIGITS  hex nibbles; digit i = data[4i+3:4i], digit 0 rightmost.
REQ-006 load  input  1  when high, data/dp/blank/lzs are captured into shadow registers.
REQ-007 dp  input  NDIGITS  decimal-point enable per digit.
REQ-008 blank  input  NDIGITS  per-digit blank request.
REQ-009 lzs  input  1  leading-zero suppression enable.
REQ-010 an  output  NDIGITS  digit select, active-low, at most one bit low.
REQ-011 seg  output  7  segments g..a, active-low, same encoding as existing single-digit decoder (0 -> 1000000, 8 -> 0000000, F -> 0001110).
REQ-012 dp_n  output  1  decimal point, active-low.

Function
REQ-013 Shadow registers SHALL update only on a clock edge with load=1; display SHALL use shadow values only, never live inputs.
REQ-014 Divider counter SHALL count 0..CLK_DIV-1 and wrap to 0; on the wrap edge the digit index SHALL advance.
REQ-015 Digit index SHALL count 0..NDIGITS-1 and wrap to 0; each digit is thus selected for exactly CLK_DIV cycles per frame of NDIGITS*CLK_DIV cycles.
REQ-016 an, seg and dp_n SHALL be registered; they reflect index and shadow values as of the previous edge (latency 1 cycle).
REQ-017 For the selected, visible digit: an bit index low, all others high; seg = decode(shadow nibble); dp_n = ~shadow dp bit.
REQ-018 A blanked digit SHALL drive all of an high, seg = 1111111, dp_n = 1 for its slot; scan timing is unaffected.
REQ-019 With shadow lzs=1, digit i (i>0) SHALL be blanked when it and every digit above it are zero; digit 0 SHALL never be suppressed; a digit with dp set SHALL never be suppressed.
REQ-020 load during a slot SHALL take effect on outputs at the next edge without resetting divider or index.
REQ-021 Simultaneous load and divider wrap: new index and new shadow values both apply; outputs show new data at new index one cycle later.
REQ-022 NDIGITS=1: index stays 0, an[0] low continuously unless blanked.

Reset
REQ-023 With rst=1 at an edge: divider=0, index=0, shadow data=0, dp=0, blank=all-ones, lzs=0; an=all-ones, seg=1111111, dp_n=1.
REQ-024 rst SHALL override load; reset mid-frame restarts the frame at digit 0 with all digits blank until first load.

Structure
REQ-025 Shared package SHALL hold the 16 segment-pattern constants and the "all segments off" constant.
REQ-026 Combinational nibble-to-segment decoder SHALL be a sub-module seg7_decode (4-bit in, 7-bit active-low out), instantiated once on the selected nibble.
REQ-027 Divider width SHALL be $clog2(CLK_DIV), index width $clog2(NDIGITS) (min 1).

Verification (NDIGITS=4, CLK_DIV=4)
REQ-028 Reset then load data=16'h12AF, blank=0, dp=0 -> an sequence 1110,1101,1011,0111 each for 4 cycles, seg F,A,2,1 = 0001110,0001000,0100100,1111001.
REQ-029 Load data=16'h0005, lzs=1 -> digits 3..1 an=1111/seg=1111111 in their slots, digit 0 seg=0010010; with lzs=0 digits 3..1 show 1000000.
REQ-030 Load data=16'h0040, lzs=1, dp=4'b0100 -> digit 2 shows 1000000 with dp_n=0, digit 1 shows 0011001, digit 3 blank.
REQ-031 load asserted in the 3rd cycle of digit 1 slot -> new value at next edge, slot still ends after cycle 4, digit 2 follows.
REQ-032 rst asserted during digit 2 slot -> next cycle an=1111, seg=1111111; after release, frame restarts at digit 0 and stays blank until load.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants for the hex display scanner: active-low g..a patterns.
// Pure declarations; no latency, no backpressure.
package seg_scan_pkg;

  localparam logic [6:0] SEG_OFF   = 7'b1111111;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/seg_scan_decode.sv
// Nibble to active-low seven-segment (g..a) decoder.
// Combinational, zero latency; no backpressure.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed hex display scanner with shadow registers, blanking and leading-zero suppression.
// Outputs registered, 1 cycle behind index/shadow; free-running scan, no backpressure.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int NDIGITS = 8,
  parameter int CLK_DIV = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NDIGITS-1:0]   data,
  input  logic                   load,
  input  logic [NDIGITS-1:0]     dp,
  input  logic [NDIGITS-1:0]     blank,
  input  logic                   lzs,
  output logic [NDIGITS-1:0]     an,
  output logic [6:0]             seg,
  output logic                   dp_n
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);

  logic [DW-1:0]          div;
  logic [IW-1:0]          idx;
  logic [4*NDIGITS-1:0]   sh_data;
  logic [NDIGITS-1:0]     sh_dp;
  logic [NDIGITS-1:0]     sh_blank;
  logic                   sh_lzs;

  logic [NDIGITS-1:0]     supp;
  logic                   zero_run;
  logic                   visible;
  logic [3:0]             nib;
  logic [6:0]             dec_seg;
  logic [NDIGITS-1:0]     an_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      idx <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_data  <= '0;
      sh_dp    <= '0;
      sh_blank <= '1;
      sh_lzs   <= 1'b0;
    end else if (load) begin
      sh_data  <= data;
      sh_dp    <= dp;
      sh_blank <= blank;
      sh_lzs   <= lzs;
    end
  end

  // Walk down from the top digit; a digit is a leading zero while every digit
  // from the top down to it is zero. Digit 0 and dp-marked digits always show.
  always_comb begin
    zero_run = 1'b1;
    supp     = '0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (sh_data[4*i +: 4] == 4'h0);
      supp[i]  = sh_lzs && (i != 0) && zero_run && !sh_dp[i];
    end
  end

  assign nib     = sh_data[{idx, 2'b00} +: 4];
  assign visible = !sh_blank[idx] && !supp[idx];

  seg7_decode u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  always_comb begin
    an_nxt = '1;
    for (int i = 0; i < NDIGITS; i++) begin
      an_nxt[i] = !(visible && (idx == IW'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an   <= '1;
      seg  <= SEG_OFF;
      dp_n <= 1'b1;
    end else begin
      an   <= an_nxt;
      seg  <= visible ? dec_seg : SEG_OFF;
      dp_n <= !(visible && sh_dp[idx]);
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with NDIGITS=4, CLK_DIV=4.
module tb_seg_scan;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic        load;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lzs;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;

  int total = 0;
  int bad   = 0;
  int n     = 0;   // edges since the last reset edge

  seg_scan #(.NDIGITS(4), .CLK_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .load  (load),
    .dp    (dp),
    .blank (blank),
    .lzs   (lzs),
    .an    (an),
    .seg   (seg),
    .dp_n  (dp_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s n=%0d got=%b exp=%b", tag, n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  // Live inputs that differ from every shadow value used; must never reach the display.
  task automatic junk();
    data  = 16'hDEAD;
    dp    = 4'hF;
    blank = 4'b1010;
    lzs   = 1'b1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                         input logic [3:0] b, input logic z);
    data = d; dp = p; blank = b; lzs = z; load = 1'b1;
    tick();
    load = 1'b0;
    junk();
  endtask

  // Output after edge n shows the digit indexed during the previous cycle.
  task automatic check_frame(input string tag, input logic [15:0] ean,
                             input logic [27:0] eseg, input logic [3:0] edpn);
    int d;
    for (int k = 0; k < 16; k++) begin
      tick();
      d = ((n - 1) / 4) % 4;
      chk({tag, "_an"},  an,   ean[4*d +: 4]);
      chk({tag, "_seg"}, seg,  eseg[7*d +: 7]);
      chk({tag, "_dp"},  dp_n, edpn[d]);
    end
  endtask

  task automatic advance_to(input int m);
    for (int k = 0; k < 16 && (n % 16) != m; k++) tick();
  endtask

  localparam logic [15:0] AN_ALL  = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [27:0] SEG_12AF = {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110};

  initial begin
    // reset overrides a simultaneous load
    rst = 1'b1; load = 1'b1; data = 16'h12AF; dp = 4'h0; blank = 4'h0; lzs = 1'b0;
    tick();
    tick();
    chk("rst_an",  an,   4'b1111);
    chk("rst_seg", seg,  7'b1111111);
    chk("rst_dp",  dp_n, 1'b1);
    rst = 1'b0; load = 1'b0; n = 0;
    junk();
    check_frame("noload", 16'hFFFF, 28'hFFFFFFF, 4'hF);

    do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
    check_frame("basic", AN_ALL, SEG_12AF, 4'hF);

    do_load(16'h0005, 4'h0, 4'h0, 1'b1);
    check_frame("lzs_on", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010}, 4'hF);

    do_load(16'h0005, 4'h0, 4'h0, 1'b0);
    check_frame("lzs_off", AN_ALL,
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b0010010}, 4'hF);

    do_load(16'h0040, 4'b0100, 4'h0, 1'b1);
    check_frame("lzs_dp", {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1111111, 7'b1000000, 7'b0011001, 7'b1000000}, 4'b1011);

    do_load(16'h12AF, 4'h0, 4'b0010, 1'b0);
    check_frame("blank1", {4'b0111, 4'b1011, 4'b1111, 4'b1110},
                {7'b1111001, 7'b0100100, 7'b1111111, 7'b0001110}, 4'hF);

    // load captured mid-slot of digit 1
    do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
    advance_to(6);
    data = 16'h3456; dp = 4'h0; blank = 4'h0; lzs = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    junk();
    chk("mid_old_an",  an,  4'b1101);
    chk("mid_old_seg", seg, 7'b0001000);
    tick();
    chk("mid_new_an",  an,  4'b1101);
    chk("mid_new_seg", seg, 7'b0010010);
    tick();
    chk("mid_next_an",  an,  4'b1011);
    chk("mid_next_seg", seg, 7'b0011001);

    // load on the divider wrap edge
    advance_to(3);
    data = 16'h789C; dp = 4'h0; blank = 4'h0; lzs = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    junk();
    chk("wrap_old_an",  an,  4'b1110);
    chk("wrap_old_seg", seg, 7'b0000010);
    tick();
    chk("wrap_new_an",  an,  4'b1101);
    chk("wrap_new_seg", seg, 7'b0010000);

    // reset during digit 2 slot
    advance_to(10);
    chk("pre_rst_an", an, 4'b1011);
    rst = 1'b1;
    tick();
    chk("midrst_an",  an,   4'b1111);
    chk("midrst_seg", seg,  7'b1111111);
    chk("midrst_dp",  dp_n, 1'b1);
    rst = 1'b0; n = 0;
    check_frame("postrst", 16'hFFFF, 28'hFFFFFFF, 4'hF);
    do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
    check_frame("restart", AN_ALL, SEG_12AF, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
